// File: rtl/e203_soc_pad_ctrl.sv
// -----------------------------------------------------------------------------
// e203_soc_pad_ctrl
// Pad-ring and always-on control slice of the E203 SoC top.
//
// Purpose:
//   - Conditions the external reset pin into rst_sync_n (async assert,
//     synchronous deassert after SYNC_STAGES hfextclk edges).
//   - Captures boot/debug-mode straps once, on the first clock edge after
//     reset release, and derives the boot PC from them.
//   - Drives GPIO A/B pads from OUT/OE registers and synchronizes pad inputs.
//   - Ties the JTAG and QSPI pads to their idle levels.
//   - Runs a 64-bit RTC (mtime/mtimecmp) ticked by rising edges of the
//     low-frequency clock, which is sampled as ordinary asynchronous data.
//
// Ports:
//   hfextclk                     sole clock
//   io_pads_aon_erst_n_i_ival    reset pin, asynchronous, active-low
//   lfextclk                     low-frequency RTC clock (sampled as data)
//   io_pads_*_i_ival / *_o_*     pad inputs / pad drive values and enables
//   hfxoscen, lfxoscen           oscillator enables (always 1)
//   cfg_wr_en/cfg_addr/cfg_wdata single-cycle register write port
//   cfg_rdata                    combinational read data (pre-write value)
//   rst_sync_n                   conditioned reset to the subsystem
//   reset_vector                 boot PC
//   tmr_irq                      timer interrupt, mtime >= mtimecmp
// -----------------------------------------------------------------------------
module e203_soc_pad_ctrl #(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] ITCM_BASE    = 32'h8000_0000,
    parameter logic [31:0] BOOTROM_BASE = 32'h0000_1000
) (
    input  logic        hfextclk,
    input  logic        io_pads_aon_erst_n_i_ival,
    input  logic        lfextclk,
    input  logic        io_pads_aon_pmu_dwakeup_n_i_ival,
    input  logic        io_pads_bootrom_n_i_ival,
    input  logic        io_pads_dbgmode0_n_i_ival,
    input  logic        io_pads_dbgmode1_n_i_ival,
    input  logic        io_pads_dbgmode2_n_i_ival,
    input  logic [31:0] io_pads_gpioA_i_ival,
    input  logic [31:0] io_pads_gpioB_i_ival,
    output logic [31:0] io_pads_gpioA_o_oval,
    output logic [31:0] io_pads_gpioA_o_oe,
    output logic [31:0] io_pads_gpioB_o_oval,
    output logic [31:0] io_pads_gpioB_o_oe,
    input  logic        io_pads_jtag_TCK_i_ival,
    input  logic        io_pads_jtag_TMS_i_ival,
    input  logic        io_pads_jtag_TDI_i_ival,
    output logic        io_pads_jtag_TDO_o_oval,
    output logic        io_pads_jtag_TDO_o_oe,
    output logic        io_pads_qspi0_sck_o_oval,
    output logic        io_pads_qspi0_cs_0_o_oval,
    input  logic        io_pads_qspi0_dq_0_i_ival,
    output logic        io_pads_qspi0_dq_0_o_oval,
    output logic        io_pads_qspi0_dq_0_o_oe,
    input  logic        io_pads_qspi0_dq_1_i_ival,
    output logic        io_pads_qspi0_dq_1_o_oval,
    output logic        io_pads_qspi0_dq_1_o_oe,
    input  logic        io_pads_qspi0_dq_2_i_ival,
    output logic        io_pads_qspi0_dq_2_o_oval,
    output logic        io_pads_qspi0_dq_2_o_oe,
    input  logic        io_pads_qspi0_dq_3_i_ival,
    output logic        io_pads_qspi0_dq_3_o_oval,
    output logic        io_pads_qspi0_dq_3_o_oe,
    output logic        hfxoscen,
    output logic        lfxoscen,
    output logic        io_pads_aon_pmu_vddpaden_o_oval,
    output logic        io_pads_aon_pmu_padrst_o_oval,
    input  logic        cfg_wr_en,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        rst_sync_n,
    output logic [31:0] reset_vector,
    output logic        tmr_irq
);

    localparam logic [3:0] ADDR_GPIOA_OUT   = 4'h0;
    localparam logic [3:0] ADDR_GPIOA_OE    = 4'h1;
    localparam logic [3:0] ADDR_GPIOB_OUT   = 4'h2;
    localparam logic [3:0] ADDR_GPIOB_OE    = 4'h3;
    localparam logic [3:0] ADDR_GPIOA_IN    = 4'h4;
    localparam logic [3:0] ADDR_GPIOB_IN    = 4'h5;
    localparam logic [3:0] ADDR_MTIME_LO    = 4'h6;
    localparam logic [3:0] ADDR_MTIME_HI    = 4'h7;
    localparam logic [3:0] ADDR_MTIMECMP_LO = 4'h8;
    localparam logic [3:0] ADDR_MTIMECMP_HI = 4'h9;
    localparam logic [3:0] ADDR_STATUS      = 4'hA;

    logic [SYNC_STAGES-1:0]        rst_sync_r;
    logic                          strap_done_r;
    logic                          bootrom_sel_r;
    logic [2:0]                    dbg_mode_r;
    logic [SYNC_STAGES-1:0]        lf_sync_r;
    logic                          lf_prev_r;
    logic [SYNC_STAGES-1:0]        wake_sync_r;
    logic [SYNC_STAGES-1:0][31:0]  gpioa_sync_r;
    logic [SYNC_STAGES-1:0][31:0]  gpiob_sync_r;
    logic [31:0]                   gpioa_out_r;
    logic [31:0]                   gpioa_oe_r;
    logic [31:0]                   gpiob_out_r;
    logic [31:0]                   gpiob_oe_r;
    logic [63:0]                   mtime_r;
    logic [63:0]                   mtimecmp_r;
    logic                          tick_s;
    logic                          wr_s;
    logic [31:0]                   gpioa_in_s;
    logic [31:0]                   gpiob_in_s;
    logic                          wake_s;
    logic [31:0]                   status_s;
    logic [31:0]                   rdata_s;
    logic                          unused_pads_s;

    // Reset synchronizer: asserts with the pin, releases after SYNC_STAGES edges.
    always_ff @(posedge hfextclk or negedge io_pads_aon_erst_n_i_ival) begin
        if (!io_pads_aon_erst_n_i_ival) begin
            rst_sync_r <= '0;
        end else begin
            rst_sync_r <= {rst_sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_r[SYNC_STAGES-1];

    // Writes from the subsystem only count once the slice is out of reset.
    assign wr_s = cfg_wr_en & rst_sync_n;

    // Strap capture: one-shot on the first edge after reset release, frozen afterwards.
    always_ff @(posedge hfextclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            strap_done_r  <= 1'b0;
            bootrom_sel_r <= 1'b0;
            dbg_mode_r    <= 3'b000;
        end else if (!strap_done_r) begin
            strap_done_r  <= 1'b1;
            bootrom_sel_r <= ~io_pads_bootrom_n_i_ival;
            dbg_mode_r    <= ~{io_pads_dbgmode2_n_i_ival,
                               io_pads_dbgmode1_n_i_ival,
                               io_pads_dbgmode0_n_i_ival};
        end else begin
            strap_done_r  <= strap_done_r;
            bootrom_sel_r <= bootrom_sel_r;
            dbg_mode_r    <= dbg_mode_r;
        end
    end

    // Input synchronizers for lfextclk, dwakeup and both GPIO ports.
    always_ff @(posedge hfextclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            lf_sync_r    <= '0;
            lf_prev_r    <= 1'b0;
            wake_sync_r  <= '0;
            gpioa_sync_r <= '0;
            gpiob_sync_r <= '0;
        end else begin
            lf_sync_r    <= {lf_sync_r[SYNC_STAGES-2:0], lfextclk};
            lf_prev_r    <= lf_sync_r[SYNC_STAGES-1];
            wake_sync_r  <= {wake_sync_r[SYNC_STAGES-2:0], ~io_pads_aon_pmu_dwakeup_n_i_ival};
            gpioa_sync_r <= {gpioa_sync_r[SYNC_STAGES-2:0], io_pads_gpioA_i_ival};
            gpiob_sync_r <= {gpiob_sync_r[SYNC_STAGES-2:0], io_pads_gpioB_i_ival};
        end
    end

    // One-cycle pulse on each synchronized rising edge of lfextclk.
    assign tick_s     = lf_sync_r[SYNC_STAGES-1] & ~lf_prev_r;
    assign wake_s     = wake_sync_r[SYNC_STAGES-1];
    assign gpioa_in_s = gpioa_sync_r[SYNC_STAGES-1];
    assign gpiob_in_s = gpiob_sync_r[SYNC_STAGES-1];

    // GPIO output value and output-enable registers.
    always_ff @(posedge hfextclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            gpioa_out_r <= 32'h0000_0000;
            gpioa_oe_r  <= 32'h0000_0000;
            gpiob_out_r <= 32'h0000_0000;
            gpiob_oe_r  <= 32'h0000_0000;
        end else if (wr_s) begin
            case (cfg_addr)
                ADDR_GPIOA_OUT: gpioa_out_r <= cfg_wdata;
                ADDR_GPIOA_OE:  gpioa_oe_r  <= cfg_wdata;
                ADDR_GPIOB_OUT: gpiob_out_r <= cfg_wdata;
                ADDR_GPIOB_OE:  gpiob_oe_r  <= cfg_wdata;
                default: begin
                    gpioa_out_r <= gpioa_out_r;
                    gpioa_oe_r  <= gpioa_oe_r;
                    gpiob_out_r <= gpiob_out_r;
                    gpiob_oe_r  <= gpiob_oe_r;
                end
            endcase
        end else begin
            gpioa_out_r <= gpioa_out_r;
            gpioa_oe_r  <= gpioa_oe_r;
            gpiob_out_r <= gpiob_out_r;
            gpiob_oe_r  <= gpiob_oe_r;
        end
    end

    // mtime counter: a software write to either half beats a coincident tick.
    always_ff @(posedge hfextclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            mtime_r <= 64'h0;
        end else if (wr_s && (cfg_addr == ADDR_MTIME_LO)) begin
            mtime_r[31:0] <= cfg_wdata;
        end else if (wr_s && (cfg_addr == ADDR_MTIME_HI)) begin
            mtime_r[63:32] <= cfg_wdata;
        end else if (tick_s) begin
            mtime_r <= mtime_r + 64'd1;
        end else begin
            mtime_r <= mtime_r;
        end
    end

    // mtimecmp register, resets to all ones so the timer irq stays quiet.
    always_ff @(posedge hfextclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            mtimecmp_r <= {64{1'b1}};
        end else if (wr_s && (cfg_addr == ADDR_MTIMECMP_LO)) begin
            mtimecmp_r[31:0] <= cfg_wdata;
        end else if (wr_s && (cfg_addr == ADDR_MTIMECMP_HI)) begin
            mtimecmp_r[63:32] <= cfg_wdata;
        end else begin
            mtimecmp_r <= mtimecmp_r;
        end
    end

    assign status_s = {26'h0, strap_done_r, wake_s, dbg_mode_r, bootrom_sel_r};

    // Read mux: returns the register contents before any same-cycle write.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (cfg_addr)
            ADDR_GPIOA_OUT:   rdata_s = gpioa_out_r;
            ADDR_GPIOA_OE:    rdata_s = gpioa_oe_r;
            ADDR_GPIOB_OUT:   rdata_s = gpiob_out_r;
            ADDR_GPIOB_OE:    rdata_s = gpiob_oe_r;
            ADDR_GPIOA_IN:    rdata_s = gpioa_in_s;
            ADDR_GPIOB_IN:    rdata_s = gpiob_in_s;
            ADDR_MTIME_LO:    rdata_s = mtime_r[31:0];
            ADDR_MTIME_HI:    rdata_s = mtime_r[63:32];
            ADDR_MTIMECMP_LO: rdata_s = mtimecmp_r[31:0];
            ADDR_MTIMECMP_HI: rdata_s = mtimecmp_r[63:32];
            ADDR_STATUS:      rdata_s = status_s;
            default:          rdata_s = 32'h0000_0000;
        endcase
    end

    assign cfg_rdata    = rdata_s;
    assign tmr_irq      = (mtime_r >= mtimecmp_r);
    assign reset_vector = bootrom_sel_r ? BOOTROM_BASE : ITCM_BASE;

    assign io_pads_gpioA_o_oval = gpioa_out_r;
    assign io_pads_gpioA_o_oe   = gpioa_oe_r;
    assign io_pads_gpioB_o_oval = gpiob_out_r;
    assign io_pads_gpioB_o_oe   = gpiob_oe_r;

    assign io_pads_aon_pmu_padrst_o_oval   = ~rst_sync_n;
    assign io_pads_aon_pmu_vddpaden_o_oval = 1'b1;
    assign hfxoscen                        = 1'b1;
    assign lfxoscen                        = 1'b1;

    // JTAG and QSPI are not used by this SoC slice; hold them idle.
    assign io_pads_jtag_TDO_o_oval   = 1'b0;
    assign io_pads_jtag_TDO_o_oe     = 1'b0;
    assign io_pads_qspi0_sck_o_oval  = 1'b0;
    assign io_pads_qspi0_cs_0_o_oval = 1'b1;
    assign io_pads_qspi0_dq_0_o_oval = 1'b0;
    assign io_pads_qspi0_dq_0_o_oe   = 1'b0;
    assign io_pads_qspi0_dq_1_o_oval = 1'b0;
    assign io_pads_qspi0_dq_1_o_oe   = 1'b0;
    assign io_pads_qspi0_dq_2_o_oval = 1'b0;
    assign io_pads_qspi0_dq_2_o_oe   = 1'b0;
    assign io_pads_qspi0_dq_3_o_oval = 1'b0;
    assign io_pads_qspi0_dq_3_o_oe   = 1'b0;

    assign unused_pads_s = ^{io_pads_jtag_TCK_i_ival, io_pads_jtag_TMS_i_ival,
                             io_pads_jtag_TDI_i_ival, io_pads_qspi0_dq_0_i_ival,
                             io_pads_qspi0_dq_1_i_ival, io_pads_qspi0_dq_2_i_ival,
                             io_pads_qspi0_dq_3_i_ival};

endmodule

// File: tb/tb_e203_soc_pad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_e203_soc_pad_ctrl
// Directed self-checking bench for e203_soc_pad_ctrl. Inputs are driven on the
// falling edge of hfextclk and outputs are sampled 1 unit later, away from the
// active edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_e203_soc_pad_ctrl;

    logic        hfextclk = 1'b0;
    logic        erst_n;
    logic        lfextclk;
    logic        dwakeup_n;
    logic        bootrom_n;
    logic        dbg0_n, dbg1_n, dbg2_n;
    logic [31:0] gpioa_i, gpiob_i;
    logic [31:0] gpioa_oval, gpioa_oe, gpiob_oval, gpiob_oe;
    logic        tdo_oval, tdo_oe, sck_oval, cs_oval;
    logic        dq0_oval, dq0_oe, dq1_oval, dq1_oe, dq2_oval, dq2_oe, dq3_oval, dq3_oe;
    logic        hfxoscen, lfxoscen, vddpaden, padrst;
    logic        cfg_wr_en;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        rst_sync_n;
    logic [31:0] reset_vector;
    logic        tmr_irq;

    int tests_run    = 0;
    int tests_failed = 0;

    always #2 hfextclk = ~hfextclk;

    e203_soc_pad_ctrl dut (
        .hfextclk                        (hfextclk),
        .io_pads_aon_erst_n_i_ival       (erst_n),
        .lfextclk                        (lfextclk),
        .io_pads_aon_pmu_dwakeup_n_i_ival(dwakeup_n),
        .io_pads_bootrom_n_i_ival        (bootrom_n),
        .io_pads_dbgmode0_n_i_ival       (dbg0_n),
        .io_pads_dbgmode1_n_i_ival       (dbg1_n),
        .io_pads_dbgmode2_n_i_ival       (dbg2_n),
        .io_pads_gpioA_i_ival            (gpioa_i),
        .io_pads_gpioB_i_ival            (gpiob_i),
        .io_pads_gpioA_o_oval            (gpioa_oval),
        .io_pads_gpioA_o_oe              (gpioa_oe),
        .io_pads_gpioB_o_oval            (gpiob_oval),
        .io_pads_gpioB_o_oe              (gpiob_oe),
        .io_pads_jtag_TCK_i_ival         (1'b0),
        .io_pads_jtag_TMS_i_ival         (1'b1),
        .io_pads_jtag_TDI_i_ival         (1'b1),
        .io_pads_jtag_TDO_o_oval         (tdo_oval),
        .io_pads_jtag_TDO_o_oe           (tdo_oe),
        .io_pads_qspi0_sck_o_oval        (sck_oval),
        .io_pads_qspi0_cs_0_o_oval       (cs_oval),
        .io_pads_qspi0_dq_0_i_ival       (1'b1),
        .io_pads_qspi0_dq_0_o_oval       (dq0_oval),
        .io_pads_qspi0_dq_0_o_oe         (dq0_oe),
        .io_pads_qspi0_dq_1_i_ival       (1'b1),
        .io_pads_qspi0_dq_1_o_oval       (dq1_oval),
        .io_pads_qspi0_dq_1_o_oe         (dq1_oe),
        .io_pads_qspi0_dq_2_i_ival       (1'b1),
        .io_pads_qspi0_dq_2_o_oval       (dq2_oval),
        .io_pads_qspi0_dq_2_o_oe         (dq2_oe),
        .io_pads_qspi0_dq_3_i_ival       (1'b1),
        .io_pads_qspi0_dq_3_o_oval       (dq3_oval),
        .io_pads_qspi0_dq_3_o_oe         (dq3_oe),
        .hfxoscen                        (hfxoscen),
        .lfxoscen                        (lfxoscen),
        .io_pads_aon_pmu_vddpaden_o_oval (vddpaden),
        .io_pads_aon_pmu_padrst_o_oval   (padrst),
        .cfg_wr_en                       (cfg_wr_en),
        .cfg_addr                        (cfg_addr),
        .cfg_wdata                       (cfg_wdata),
        .cfg_rdata                       (cfg_rdata),
        .rst_sync_n                      (rst_sync_n),
        .reset_vector                    (reset_vector),
        .tmr_irq                         (tmr_irq)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge hfextclk);
        cfg_wr_en = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge hfextclk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic cfg_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge hfextclk);
        cfg_addr = addr;
        #1;
        data = cfg_rdata;
    endtask

    // One full lfextclk period of 66 time units, starting on a falling edge.
    task automatic lf_period();
        @(negedge hfextclk);
        lfextclk = 1'b1;
        #33;
        lfextclk = 1'b0;
        #33;
    endtask

    logic [31:0] rd;
    logic [31:0] rd_hi;

    initial begin
        erst_n    = 1'b0;
        lfextclk  = 1'b0;
        dwakeup_n = 1'b1;
        bootrom_n = 1'b0;
        {dbg2_n, dbg1_n, dbg0_n} = 3'b101;
        gpioa_i   = 32'h0000_0000;
        gpiob_i   = 32'h0000_0000;
        cfg_wr_en = 1'b0;
        cfg_addr  = 4'h0;
        cfg_wdata = 32'h0000_0000;

        // Reset release at t=120; posedges at 122 and 126.
        #120;
        erst_n = 1'b1;
        #4;                                           // t=124, one edge seen
        check("rst_after_1_edge", {63'h0, rst_sync_n}, 64'h0);
        check("padrst_in_reset", {63'h0, padrst}, 64'h1);
        check("rstvec_in_reset", {32'h0, reset_vector}, 64'h8000_0000);
        #3;                                           // t=127, two edges seen
        check("rst_after_2_edges", {63'h0, rst_sync_n}, 64'h1);
        check("padrst_released", {63'h0, padrst}, 64'h0);
        check("gpio_pads_reset", {gpioa_oval | gpioa_oe, gpiob_oval | gpiob_oe}, 64'h0);
        check("irq_reset", {63'h0, tmr_irq}, 64'h0);
        check("tieoffs", {52'h0, tdo_oval, tdo_oe, sck_oval, cs_oval,
                          dq0_oval, dq0_oe, dq1_oval, dq1_oe,
                          dq2_oval, dq2_oe, dq3_oval, dq3_oe},
              64'h100);
        check("osc_vdd_en", {61'h0, hfxoscen, lfxoscen, vddpaden}, 64'h7);

        // Boot strap captured as boot ROM; toggling the pin later is ignored.
        repeat (2) @(negedge hfextclk);
        check("rstvec_bootrom", {32'h0, reset_vector}, 64'h0000_1000);
        bootrom_n = 1'b1;
        {dbg2_n, dbg1_n, dbg0_n} = 3'b000;
        repeat (3) @(negedge hfextclk);
        check("rstvec_frozen", {32'h0, reset_vector}, 64'h0000_1000);
        cfg_read(4'hA, rd);
        check("status_straps", {32'h0, rd}, 64'h25);

        // GPIO drive and input synchronization.
        cfg_write(4'h0, 32'hA5A5_0F0F);
        cfg_write(4'h1, 32'hFFFF_FFFF);
        check("gpioa_oval", {32'h0, gpioa_oval}, 64'hA5A5_0F0F);
        check("gpioa_oe", {32'h0, gpioa_oe}, 64'hFFFF_FFFF);
        check("gpiob_untouched", {gpiob_oval, gpiob_oe}, 64'h0);
        cfg_write(4'h2, 32'h0000_00C3);
        check("gpiob_oval", {32'h0, gpiob_oval}, 64'hC3);
        cfg_read(4'h0, rd);
        check("rd_gpioa_out", {32'h0, rd}, 64'hA5A5_0F0F);
        gpiob_i = 32'h1234_5678;
        cfg_read(4'h5, rd);
        check("gpiob_in_1cyc", {32'h0, rd}, 64'h0);
        cfg_read(4'h5, rd);
        check("gpiob_in_2cyc", {32'h0, rd}, 64'h1234_5678);
        cfg_write(4'h5, 32'hDEAD_BEEF);
        cfg_read(4'h5, rd);
        check("ro_write_ignored", {32'h0, rd}, 64'h1234_5678);
        cfg_write(4'hC, 32'hDEAD_BEEF);
        cfg_read(4'hC, rd);
        check("unmapped_reads_0", {32'h0, rd}, 64'h0);

        // RTC with compare at 3: irq follows mtime >= 3.
        cfg_write(4'h9, 32'h0000_0000);
        cfg_write(4'h8, 32'h0000_0003);
        check("irq_cmp3_mtime0", {63'h0, tmr_irq}, 64'h0);
        for (int i = 1; i <= 5; i++) begin
            lf_period();
            cfg_read(4'h6, rd);
            check($sformatf("mtime_lo_%0d", i), {32'h0, rd}, 64'(i));
            check($sformatf("irq_at_%0d", i), {63'h0, tmr_irq}, (i >= 3) ? 64'h1 : 64'h0);
        end
        cfg_write(4'h8, 32'hFFFF_FFFF);
        cfg_write(4'h9, 32'hFFFF_FFFF);
        check("irq_cleared", {63'h0, tmr_irq}, 64'h0);

        // 64-bit wrap.
        cfg_write(4'h7, 32'hFFFF_FFFF);
        cfg_write(4'h6, 32'hFFFF_FFFF);
        check("irq_max_eq_cmp", {63'h0, tmr_irq}, 64'h1);
        lf_period();
        cfg_read(4'h6, rd);
        cfg_read(4'h7, rd_hi);
        check("mtime_wrap", {rd_hi, rd}, 64'h0);

        // Write coincident with the tick: rising lfextclk at negedge n gives
        // tick active for the posedge at n+10, which the write also uses.
        @(negedge hfextclk);
        lfextclk = 1'b1;
        @(negedge hfextclk);
        @(negedge hfextclk);
        cfg_wr_en = 1'b1;
        cfg_addr  = 4'h6;
        cfg_wdata = 32'h0000_0007;
        @(negedge hfextclk);
        cfg_wr_en = 1'b0;
        repeat (4) @(negedge hfextclk);
        cfg_read(4'h6, rd);
        check("write_beats_tick", {32'h0, rd}, 64'h7);
        lfextclk = 1'b0;

        // Mid-operation reset: everything returns to reset values at once.
        @(negedge hfextclk);
        #1;
        erst_n = 1'b0;
        #1;
        check("mid_rst_sync_n", {63'h0, rst_sync_n}, 64'h0);
        check("mid_rst_gpioa", {gpioa_oval, gpioa_oe}, 64'h0);
        check("mid_rst_padrst", {63'h0, padrst}, 64'h1);
        check("mid_rst_rstvec", {32'h0, reset_vector}, 64'h8000_0000);
        cfg_read(4'h6, rd);
        check("mid_rst_mtime", {32'h0, rd}, 64'h0);
        cfg_read(4'h8, rd);
        check("mid_rst_mtimecmp", {32'h0, rd}, 64'hFFFF_FFFF);
        cfg_read(4'hA, rd);
        check("mid_rst_status", {32'h0, rd}, 64'h0);
        cfg_write(4'h0, 32'h1111_1111);

        // Second boot from ITCM with wakeup asserted and debug straps 101.
        bootrom_n = 1'b1;
        dwakeup_n = 1'b0;
        {dbg2_n, dbg1_n, dbg0_n} = 3'b101;
        @(negedge hfextclk);
        erst_n = 1'b1;
        repeat (6) @(negedge hfextclk);
        check("rstvec_itcm", {32'h0, reset_vector}, 64'h8000_0000);
        cfg_read(4'hA, rd);
        check("status_itcm_wake", {32'h0, rd}, 64'h34);
        cfg_read(4'h0, rd);
        check("write_in_reset_ignored", {32'h0, rd}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
